// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster counters, VGA sync/blank decode
// and a short delay line that aligns sync with drawing.
module vga_scan_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               clkEn,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               startOfFrame,
  output logic               hSyncN,
  output logic               vSyncN,
  output logic               blankN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic signed [10:0] X_LAST = 11'(H_TOTAL - 1);
  localparam logic signed [10:0] Y_LAST = 11'(V_TOTAL - 1);
  localparam logic signed [10:0] X_VIS  = 11'(H_ACTIVE);
  localparam logic signed [10:0] Y_VIS  = 11'(V_ACTIVE);
  localparam logic signed [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic signed [10:0] HS_END =
    11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic signed [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic signed [10:0] VS_END =
    11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic x_wrap;
  logic y_wrap;
  logic hs0;
  logic vs0;
  logic bl0;

  assign x_wrap = (pixelX == X_LAST);
  assign y_wrap = (pixelY == Y_LAST);

  // Raster counters; reset parks them on the last pixel of a frame
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pixelX <= X_LAST;
      pixelY <= Y_LAST;
    end else if (clkEn) begin
      if (x_wrap) begin
        pixelX <= '0;
        pixelY <= y_wrap ? '0 : pixelY + 11'sd1;
      end else begin
        pixelX <= pixelX + 11'sd1;
      end
    end
  end

  // Single-clk frame-start pulse on the (last,last)->(0,0) step
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      startOfFrame <= 1'b0;
    end else begin
      startOfFrame <= clkEn & x_wrap & y_wrap;
    end
  end

  // Stage-0 decode straight from the counter registers
  always_comb begin
    hs0 = ~((pixelX >= HS_BEG) && (pixelX <= HS_END));
    vs0 = ~((pixelY >= VS_BEG) && (pixelY <= VS_END));
    bl0 = (pixelX < X_VIS) && (pixelY < Y_VIS);
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign hSyncN = hs0;
      assign vSyncN = vs0;
      assign blankN = bl0;
    end else begin : g_dly
      logic [PIPE_DELAY-1:0] hs_q;
      logic [PIPE_DELAY-1:0] vs_q;
      logic [PIPE_DELAY-1:0] bl_q;

      // Shift decode through PIPE_DELAY pixel steps
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          hs_q <= '1;
          vs_q <= '1;
          bl_q <= '0;
        end else if (clkEn) begin
          hs_q <= PIPE_DELAY'({hs_q, hs0});
          vs_q <= PIPE_DELAY'({vs_q, vs0});
          bl_q <= PIPE_DELAY'({bl_q, bl0});
        end
      end

      assign hSyncN = hs_q[PIPE_DELAY-1];
      assign vSyncN = vs_q[PIPE_DELAY-1];
      assign blankN = bl_q[PIPE_DELAY-1];
    end
  endgenerate

endmodule
